// File: rtl/uart_rx_deserializer_if.sv
// Word handoff from the UART receiver to the RX FIFO write port.
interface uart_rx_deserializer_if #(
    parameter int DATASIZE = 20
);
    logic [DATASIZE-1:0] data_o;
    logic                valid_o;
    logic                ready_i;

    // Receiver drives the word, FIFO side drives ready.
    modport master (output data_o, output valid_o, input ready_i);
    modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizes rx_i, recovers 8N1-style frames of
// DATASIZE data bits (LSB first, one stop bit) and holds each word in a
// single-entry output buffer with a valid/ready handshake.
module uart_rx_deserializer #(
    parameter int DATASIZE    = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  avl_clk_i,
    input  logic                  avl_reset_i,
    input  logic [15:0]           clk_per_bit_i,
    input  logic                  rx_i,
    uart_rx_deserializer_if.master rx_if,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  busy_o
);
    localparam int IW = $clog2(DATASIZE);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATASIZE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t                     state;
    logic [SYNC_STAGES-1:0]     sync_q;
    logic                       rx_s;
    logic [15:0]                cpb;
    logic [15:0]                cnt;
    logic [IW-1:0]              bit_idx;
    logic [DATASIZE-1:0]        shift;
    logic [DATASIZE-1:0]        data_q;
    logic                       valid_q;
    logic [15:0]                cpb_eff;
    logic [15:0]                half_m1;
    logic [15:0]                cpb_m1;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    // Divisors below 4 leave no room for a mid-bit sample, so clamp them.
    assign cpb_eff = (clk_per_bit_i < 16'd4) ? 16'd4 : clk_per_bit_i;
    assign half_m1 = (cpb >> 1) - 16'd1;
    assign cpb_m1  = cpb - 16'd1;

    assign rx_if.data_o  = data_q;
    assign rx_if.valid_o = valid_q;

    // Metastability synchronizer; resets to the idle (high) line level.
    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) sync_q <= '1;
        else              sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end

    // Frame FSM, shift register and single-entry output buffer.
    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) begin
            state       <= IDLE;
            cpb         <= '0;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            // Consumer takes the word; a load below in the same cycle wins.
            if (valid_q && rx_if.ready_i) valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        cpb    <= cpb_eff;   // frozen for the whole frame
                        busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == half_m1) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end else begin
                            // Too short to be a start bit: treat as noise.
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == cpb_m1) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[DATASIZE-1:1]};  // LSB arrives first
                        if (bit_idx == LAST_BIT) state <= STOP;
                        else                     bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == cpb_m1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            if (!valid_q || rx_if.ready_i) begin
                                data_q  <= shift;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    // A line stuck low must not look like a fresh start bit.
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: directed scenarios plus randomized frames, checked
// against a frame-level model (expected word queue and pulse counts).
module tb_uart_rx_deserializer;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   cpb_in = 16'd8;
    logic          rx = 1'b1;
    logic          ferr, ovr, busy;

    uart_rx_deserializer_if #(.DATASIZE(DW)) rx_if ();

    uart_rx_deserializer #(.DATASIZE(DW), .SYNC_STAGES(2)) dut (
        .avl_clk_i     (clk),
        .avl_reset_i   (rst_n),
        .clk_per_bit_i (cpb_in),
        .rx_i          (rx),
        .rx_if         (rx_if.master),
        .frame_err_o   (ferr),
        .overrun_o     (ovr),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    logic ready = 1'b1;
    assign rx_if.ready_i = ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] exp_q[$];
    int exp_ferr = 0, exp_ovr = 0;
    int obs_ferr = 0, obs_ovr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: accepted words against the model, pulse counting, hold stability.
    logic          prev_v = 1'b0, prev_r = 1'b0;
    logic [DW-1:0] prev_d = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", rx_if.valid_o, 1);
                chk("hold_data", rx_if.data_o, prev_d);
            end
            if (ferr || ovr) chk("pulse_excl", ferr & ovr, 0);
            if (ferr) obs_ferr++;
            if (ovr)  obs_ovr++;
            if (rx_if.valid_o && ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", rx_if.data_o, 32'hDEAD);
                else begin
                    logic [DW-1:0] w;
                    w = exp_q.pop_front();
                    chk("word", rx_if.data_o, w);
                end
            end
            prev_v = rx_if.valid_o;
            prev_r = ready;
            prev_d = rx_if.data_o;
        end
    end

    // Drive one frame at 'per' cycles/bit. Model outcome is decided up front
    // from the frame contents and the buffer occupancy seen by the model.
    task automatic send_frame(input logic [DW-1:0] w, input int per, input logic stop,
                              input int chg_bit, input logic [15:0] chg_val, input int rst_bit);
        if (rst_bit < 0) begin
            if (!stop)                            exp_ferr++;
            else if (!ready && exp_q.size() > 0)  exp_ovr++;
            else                                  exp_q.push_back(w);
        end
        rx = 1'b0;
        tick(per);
        for (int i = 0; i < DW; i++) begin
            if (i == chg_bit) cpb_in = chg_val;
            rx = w[i];
            if (i == rst_bit) begin
                tick(per / 2);
                chk("busy_before_rst", busy, 1);
                rst_n = 1'b0;
                #1;
                chk("rst_valid", rx_if.valid_o, 0);
                chk("rst_data", rx_if.data_o, 0);
                chk("rst_busy", busy, 0);
                chk("rst_pulses", {ferr, ovr}, 0);
                exp_q.delete();
                rx = 1'b1;
                tick(4);
                rst_n = 1'b1;
                tick(2);
                return;
            end
            tick(per);
        end
        rx = stop;
        tick(per);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_ferr"}, obs_ferr, exp_ferr);
        chk({tag, "_ovr"}, obs_ovr, exp_ovr);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #1;
        chk("reset_valid", rx_if.valid_o, 0);
        chk("reset_data", rx_if.data_o, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pulses", {ferr, ovr}, 0);
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // Nominal frame
        cpb_in = 16'd8; ready = 1'b1;
        send_frame(20'hABCDE, 8, 1'b1, -1, 16'd0, -1);
        rx = 1'b1; tick(10);
        check_counts("nominal");

        // Back-pressure and overrun
        ready = 1'b0;
        send_frame(20'h00001, 8, 1'b1, -1, 16'd0, -1);
        rx = 1'b1; tick(4);
        send_frame(20'hFFFFF, 8, 1'b1, -1, 16'd0, -1);
        rx = 1'b1; tick(4);
        chk("bp_valid", rx_if.valid_o, 1);
        chk("bp_data", rx_if.data_o, 20'h00001);
        chk("bp_ovr", obs_ovr, exp_ovr);
        ready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick(1);
        chk("bp_drain", exp_q.size(), 0);
        tick(2);
        chk("bp_valid_low", rx_if.valid_o, 0);
        check_counts("overrun");

        // Framing error with line held low
        cpb_in = 16'd16;
        send_frame(20'h12345, 16, 1'b0, -1, 16'd0, -1);
        tick(20);
        chk("ferr_busy_low", busy, 1);
        chk("ferr_no_valid", rx_if.valid_o, 0);
        tick(20);
        rx = 1'b1;
        tick(6);
        chk("ferr_busy_released", busy, 0);
        send_frame(20'h54321, 16, 1'b1, -1, 16'd0, -1);
        rx = 1'b1; tick(10);
        check_counts("ferr");

        // Start glitch
        rx = 1'b0; tick(2); rx = 1'b1;
        tick(4);
        chk("glitch_busy", busy, 1);
        tick(20);
        chk("glitch_idle", busy, 0);
        check_counts("glitch");

        // Divisor clamp and latch
        cpb_in = 16'd2;
        send_frame(20'h0F0F0, 4, 1'b1, -1, 16'd0, -1);
        rx = 1'b1; tick(8);
        cpb_in = 16'd8;
        send_frame(20'h6A5C3, 8, 1'b1, 5, 16'd20, -1);
        rx = 1'b1; tick(10);
        check_counts("latch");

        // Reset mid-frame with a held word in the buffer
        cpb_in = 16'd8; ready = 1'b0;
        send_frame(20'h3C3C3, 8, 1'b1, -1, 16'd0, -1);
        rx = 1'b1; tick(4);
        chk("pre_rst_valid", rx_if.valid_o, 1);
        send_frame(20'h00000, 8, 1'b1, -1, 16'd0, 10);
        ready = 1'b1;
        send_frame(20'h00AA5, 8, 1'b1, -1, 16'd0, -1);
        rx = 1'b1; tick(10);
        check_counts("rst");

        // Randomized frames: divisor, data, stop-bit errors and gaps
        for (int n = 0; n < 25; n++) begin
            logic [15:0]   c;
            int            per;
            logic [DW-1:0] w;
            logic          stop;
            c    = 16'($urandom_range(0, 20));
            per  = (c < 4) ? 4 : int'(c);
            w    = DW'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            cpb_in = c;
            send_frame(w, per, stop, -1, 16'd0, -1);
            if (!stop) tick($urandom_range(0, 20));
            rx = 1'b1;
            tick($urandom_range(1, 8));
        end
        tick(60);
        check_counts("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout got 1 exp 0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
Receive front end of the UART datapath. Samples the asynchronous serial line, recovers DATASIZE-bit frames (1 start bit, DATASIZE data bits LSB first, 1 stop bit, no parity) and hands each word to the Avalon UART interface RX FIFO over a valid/ready handshake. It sits directly upstream of the interface RX FIFO write port. It reports framing errors and overruns as one-cycle pulses for the interface status register.

Parameters:
DATASIZE, 20, number of data bits per frame and width of data_o (legal range 5..32)
SYNC_STAGES, 2, flip-flops in the rx_i synchronizer (minimum 2)

Ports:
avl_clk_i  input  1  system clock; all logic on the rising edge
avl_reset_i  input  1  reset, asynchronous, active-low
clk_per_bit_i  input  16  clock cycles per bit period, from the interface baud register
rx_i  input  1  asynchronous serial line; idles high
data_o  output  DATASIZE  received word
valid_o  output  1  data_o holds a word not yet accepted
ready_i  input  1  consumer (RX FIFO) accepts the word this cycle when valid_o=1
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: completed word dropped because the buffer was full
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (avl_reset_i=0, asynchronous): state=IDLE, synchronizer flops=1, counters=0, data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0. If reset is asserted mid-frame, the partial frame is discarded and no pulse is emitted.
- rx_s is rx_i delayed by SYNC_STAGES flops. All timing below refers to rx_s.
- Effective divisor cpb = max(clk_per_bit_i, 4). It is latched on leaving IDLE and held constant for the whole frame.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rx_s=0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt=(cpb>>1)-1, sample rx_s:
  - rx_s=0: go to DATA, cnt=0, bit index=0.
  - rx_s=1: glitch; return to IDLE with no pulse.
- DATA: at cnt=cpb-1, sample rx_s into shift register bit[index] (LSB first) and clear cnt. After bit DATASIZE-1 is sampled, go to STOP.
- STOP: at cnt=cpb-1, sample rx_s:
  - rx_s=1: frame good; go to IDLE.
  - rx_s=0: frame_err_o=1 for one cycle, word discarded; go to WAIT_HIGH.
- WAIT_HIGH: go to IDLE when rx_s=1. This prevents a held-low line from retriggering a start.
- Output buffer (single entry), on a good stop sample:
  - If valid_o=0, or valid_o=1 with ready_i=1 in the same cycle: data_o loads the word and valid_o=1 on the next edge. Latency is 1 cycle from the stop-bit sample.
  - If valid_o=1 and ready_i=0: overrun_o=1 for one cycle, the new word is dropped, and data_o/valid_o are unchanged.
- Handshake: when valid_o=1 and ready_i=1, the word is consumed and valid_o falls next cycle unless a new word loads that same cycle. While valid_o=1 and ready_i=0, data_o and valid_o are stable. ready_i is ignored while valid_o=0.
- Changes to clk_per_bit_i mid-frame have no effect until the next start bit.
- frame_err_o and overrun_o never assert in the same cycle; a framing error never loads the buffer.

Test Plan:
- Nominal frame: cpb=8, ready_i=1, frame carrying 0xABCDE -> valid_o pulses once with data_o=0x0ABCDE; frame_err_o=0, overrun_o=0.
- Back-pressure and overrun: ready_i=0, frames 0x00001 then 0xFFFFF -> data_o holds 0x00001 with valid_o high throughout; overrun_o pulses once at the second stop sample; ready_i=1 then drains 0x00001 only.
- Framing error: cpb=16, frame 0x12345 with stop bit=0, line held low 40 cycles, then high -> frame_err_o pulses once, valid_o stays 0, busy_o stays high until the line returns high, then the next frame 0x54321 is received correctly.
- Start glitch: 2-cycle low pulse on rx_i with cpb=16 -> returns to IDLE, no valid_o, frame_err_o or overrun_o.
- Divisor clamp and latch: clk_per_bit_i=2 with a frame bit-timed at 4 cycles/bit carrying 0x0F0F0 -> received correctly. Then clk_per_bit_i changes from 8 to 20 mid-frame -> the frame completes at 8 cycles/bit with correct data.
- Reset mid-frame: assert avl_reset_i=0 during DATA bit 10 -> all outputs 0 immediately (asynchronous); after release, the next frame 0x00AA5 is received cleanly.
